// File: rtl/ref_rd_resp.sv
// Reference-pixel read responder: turns generator addresses into SRAM reads and returns the pixels in request order.
// Latency: request cycle 0 -> mem_rd_en in cycle 1 -> data capture in cycle 2 -> dout_valid in cycle 3.
// Backpressure: pause rises when buffered plus in-flight pixels would fill the FIFO, and in DRAIN/DONE.
module ref_rd_resp #(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 8384611
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_valid,
  input  logic              finish_in,
  output logic              pause,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              done,
  output logic              addr_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [PTR_W+1:0] CREDIT_MAX = (PTR_W+2)'(DEPTH);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cap_q;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   fifo_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;

  logic                accept, legal, push, pop;
  logic [1:0]          inflight;
  logic [PTR_W+1:0]    credit_used;

  // Every accepted legal read owns a FIFO slot from issue until it is popped.
  assign inflight    = {1'b0, rd_en_q} + {1'b0, cap_q};
  assign credit_used = {1'b0, count_q} + {{PTR_W{1'b0}}, inflight};
  assign legal       = {1'b0, req_addr} < ADDR_LIMIT;
  assign accept      = req_valid && !pause;
  assign push        = cap_q;
  assign dout_valid  = count_q != '0;
  assign pop         = dout_valid && dout_ready;
  assign dout        = dout_valid ? fifo_q[rd_ptr_q] : '0;
  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_en_q;
  assign addr_err    = err_q;

  // FSM next state plus the credit-based pause and sticky done outputs.
  always_comb begin
    state_d = state_q;
    pause   = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      RUN: begin
        pause = credit_used >= CREDIT_MAX;
        if (finish_in) state_d = DRAIN;
      end
      DRAIN: begin
        if (count_q == '0 && inflight == 2'd0) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Read issue: legal accepts strobe the SRAM, illegal ones only raise the error flag.
  always_comb begin
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    err_d   = err_q;
    if (accept) begin
      if (legal) begin
        rd_en_d = 1'b1;
        addr_d  = req_addr;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // FIFO pointer/count next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  // State, read-issue and capture registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      cap_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      cap_q   <= rd_en_q;
      err_q   <= err_d;
    end
  end

  // FIFO bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage: SRAM data is captured the cycle after the strobe; credit guarantees a free slot.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_rdata;
  end

endmodule
